// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing one UART transmit channel between two byte sources.
// Latency: grant 1 cycle after request, strobe 1 cycle after accept; backpressure: tx_buffer_full gates ready, one holdoff cycle per byte.
module uart_tx_arbiter #(
   parameter int MAX_BURST    = 16,
   parameter int IDLE_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] tx_data,
   output logic       write_tx_data,
   input  logic       tx_buffer_full,
   output logic [1:0] grant,
   output logic       busy
);

   typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, HOLDOFF0, HOLDOFF1} state_t;

   localparam logic [7:0] MAX_B  = 8'(MAX_BURST);
   localparam logic [7:0] IDLE_T = 8'(IDLE_TIMEOUT);

   state_t     state_q, state_d;
   logic       rr_q, rr_d;
   logic [7:0] burst_cnt_q, burst_cnt_d;
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic       last_q, last_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       wr_q, wr_d;

   logic       own1;
   logic       cur_vld;
   logic [7:0] cur_dat;
   logic       cur_last;
   logic       cur_rdy;
   logic       rel;

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

   assign own1     = (state_q == GRANT1) || (state_q == HOLDOFF1);
   assign cur_vld  = own1 ? req1_valid : req0_valid;
   assign cur_dat  = own1 ? req1_data  : req0_data;
   assign cur_last = own1 ? req1_last  : req0_last;

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      burst_cnt_d = burst_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      last_d      = last_q;
      tx_data_d   = tx_data_q;
      wr_d        = 1'b0;
      cur_rdy     = 1'b0;
      rel         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0_valid && (!req1_valid || !rr_q)) state_d = GRANT0;
            else if (req1_valid)                      state_d = GRANT1;
         end
         GRANT0, GRANT1: begin
            cur_rdy = cur_vld && !tx_buffer_full;
            if (cur_rdy) begin
               tx_data_d   = cur_dat;
               wr_d        = 1'b1;
               burst_cnt_d = sat_inc(burst_cnt_q);
               idle_cnt_d  = 8'd0;
               last_d      = cur_last;
               state_d     = own1 ? HOLDOFF1 : HOLDOFF0;
            end else if (!cur_vld) begin
               // Only a silent owner ages toward timeout; a full UART does not count.
               idle_cnt_d = sat_inc(idle_cnt_q);
               if (sat_inc(idle_cnt_q) == IDLE_T) rel = 1'b1;
            end
         end
         HOLDOFF0, HOLDOFF1: begin
            if (last_q || (burst_cnt_q == MAX_B)) rel = 1'b1;
            else state_d = own1 ? GRANT1 : GRANT0;
         end
         default: state_d = IDLE;
      endcase
      if (rel) begin
         state_d     = IDLE;
         rr_d        = !own1;
         burst_cnt_d = 8'd0;
         idle_cnt_d  = 8'd0;
         last_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_q        <= 1'b0;
         burst_cnt_q <= 8'd0;
         idle_cnt_q  <= 8'd0;
         last_q      <= 1'b0;
         tx_data_q   <= 8'd0;
         wr_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         burst_cnt_q <= burst_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         last_q      <= last_d;
         tx_data_q   <= tx_data_d;
         wr_q        <= wr_d;
      end
   end

   assign req0_ready    = cur_rdy && !own1;
   assign req1_ready    = cur_rdy && own1;
   assign tx_data       = tx_data_q;
   assign write_tx_data = wr_q;
   assign grant         = {(state_q == GRANT1) || (state_q == HOLDOFF1),
                           (state_q == GRANT0) || (state_q == HOLDOFF0)};
   assign busy          = |grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, strobe log, hand-computed expectations.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       req0_valid, req0_last, req0_ready;
   logic [7:0] req0_data;
   logic       req1_valid, req1_last, req1_ready;
   logic [7:0] req1_data;
   logic [7:0] tx_data;
   logic       write_tx_data;
   logic       tx_buffer_full;
   logic [1:0] grant;
   logic       busy;

   uart_tx_arbiter #(.MAX_BURST(16), .IDLE_TIMEOUT(64)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .tx_data(tx_data), .write_tx_data(write_tx_data), .tx_buffer_full(tx_buffer_full),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [9:0] obs_dat[$];
   int         obs_cyc[$];
   logic [1:0] s_g;
   logic       s_rdy0, s_rdy1, s_wr;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive();
      req0_valid = (q0.size() != 0);
      req0_data  = (q0.size() != 0) ? q0[0][7:0] : 8'h00;
      req0_last  = (q0.size() != 0) ? q0[0][8]   : 1'b0;
      req1_valid = (q1.size() != 0);
      req1_data  = (q1.size() != 0) ? q1[0][7:0] : 8'h00;
      req1_last  = (q1.size() != 0) ? q1[0][8]   : 1'b0;
   endtask

   task automatic step();
      logic acc0, acc1;
      @(negedge clk);
      s_g = grant; s_rdy0 = req0_ready; s_rdy1 = req1_ready; s_wr = write_tx_data;
      if (write_tx_data) begin
         obs_dat.push_back({grant, tx_data});
         obs_cyc.push_back(cyc);
      end
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      q0.delete(); q1.delete();
      tx_buffer_full = 1'b0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      obs_dat.delete(); obs_cyc.delete();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int         c0;
      logic [1:0] gl[80];
      logic [9:0] exp_q[$];
      int         rdy_hi, wr_hi;

      reset = 1'b0; tx_buffer_full = 1'b0;
      drive();
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr", 32'(write_tx_data), 0);
      chk("rst_txd", 32'(tx_data), 0);
      do_reset();

      // 1: two-byte packet from req0
      q0.push_back({1'b0, 8'h41}); q0.push_back({1'b1, 8'h42}); drive();
      c0 = cyc;
      run(8);
      chk("t1_cnt", 32'(obs_dat.size()), 2);
      if (obs_dat.size() == 2) begin
         chk("t1_b0", 32'(obs_dat[0]), {22'd0, 2'b01, 8'h41});
         chk("t1_b1", 32'(obs_dat[1]), {22'd0, 2'b01, 8'h42});
         chk("t1_c0", 32'(obs_cyc[0]), 32'(c0 + 2));
         chk("t1_c1", 32'(obs_cyc[1]), 32'(c0 + 4));
      end
      chk("t1_rel", 32'(grant), 0);
      chk("t1_busy", 32'(busy), 0);

      // 2: alternation over four 3-byte packets
      do_reset();
      exp_q.delete();
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < 3; b++) begin
            q0.push_back({b == 2, 8'(8'h10 + 3 * p + b)});
            q1.push_back({b == 2, 8'(8'h20 + 3 * p + b)});
         end
      for (int p = 0; p < 2; p++) begin
         for (int b = 0; b < 3; b++) exp_q.push_back({2'b01, 8'(8'h10 + 3 * p + b)});
         for (int b = 0; b < 3; b++) exp_q.push_back({2'b10, 8'(8'h20 + 3 * p + b)});
      end
      drive();
      run(50);
      chk("t2_cnt", 32'(obs_dat.size()), 12);
      for (int i = 0; i < 12 && i < obs_dat.size(); i++)
         chk($sformatf("t2_b%0d", i), 32'(obs_dat[i]), 32'(exp_q[i]));

      // 3: req1 long stream cut at 16 bytes, req0 packet slips in
      do_reset();
      exp_q.delete();
      for (int i = 0; i < 40; i++) q1.push_back({1'b0, 8'(8'h80 + i)});
      drive();
      run(2);
      q0.push_back({1'b0, 8'h51}); q0.push_back({1'b1, 8'h52}); drive();
      for (int i = 0; i < 16; i++) exp_q.push_back({2'b10, 8'(8'h80 + i)});
      exp_q.push_back({2'b01, 8'h51}); exp_q.push_back({2'b01, 8'h52});
      for (int i = 16; i < 40; i++) exp_q.push_back({2'b10, 8'(8'h80 + i)});
      run(130);
      chk("t3_cnt", 32'(obs_dat.size()), 42);
      for (int i = 0; i < 42 && i < obs_dat.size(); i++)
         chk($sformatf("t3_b%0d", i), 32'(obs_dat[i]), 32'(exp_q[i]));

      // 4: UART full for 20 cycles mid-burst
      do_reset();
      for (int i = 0; i < 6; i++) q0.push_back({i == 5, 8'(8'h60 + i)});
      drive();
      c0 = cyc;
      run(5);
      tx_buffer_full = 1'b1;
      rdy_hi = 0; wr_hi = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (s_rdy0) rdy_hi++;
         if (s_wr) wr_hi++;
      end
      chk("t4_rdy_full", 32'(rdy_hi), 0);
      chk("t4_wr_full", 32'(wr_hi), 0);
      chk("t4_hold", 32'(grant), 32'(2'b01));
      tx_buffer_full = 1'b0;
      run(20);
      chk("t4_cnt", 32'(obs_dat.size()), 6);
      if (obs_dat.size() == 6) begin
         chk("t4_resume_c", 32'(obs_cyc[2]), 32'(c0 + 26));
         chk("t4_resume_d", 32'(obs_dat[2]), {22'd0, 2'b01, 8'h62});
         chk("t4_last", 32'(obs_dat[5]), {22'd0, 2'b01, 8'h65});
      end
      chk("t4_rel", 32'(grant), 0);

      // 5: req0 goes silent after one byte, timeout hands over to req1
      do_reset();
      q0.push_back({1'b0, 8'h70}); drive();
      c0 = cyc;
      step(); gl[0] = s_g;
      q1.push_back({1'b1, 8'h71}); drive();
      for (int k = 1; k < 80; k++) begin
         step(); gl[k] = s_g;
      end
      chk("t5_held", 32'(gl[66]), 32'(2'b01));
      chk("t5_rel", 32'(gl[67]), 0);
      chk("t5_g1", 32'(gl[68]), 32'(2'b10));
      chk("t5_cnt", 32'(obs_dat.size()), 2);
      if (obs_dat.size() == 2) begin
         chk("t5_b1", 32'(obs_dat[1]), {22'd0, 2'b10, 8'h71});
         chk("t5_c1", 32'(obs_cyc[1]), 32'(c0 + 69));
      end

      // 6: async reset during a req1 strobe, then req0 wins the restart
      do_reset();
      q0.push_back({1'b1, 8'h90});
      q1.push_back({1'b0, 8'hA0}); q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b1, 8'hA2});
      drive();
      run(5);
      @(negedge clk);
      chk("t6_pre_wr", 32'(write_tx_data), 1);
      chk("t6_pre_g", 32'(grant), 32'(2'b10));
      reset = 1'b0;
      #1;
      chk("t6_wr", 32'(write_tx_data), 0);
      chk("t6_grant", 32'(grant), 0);
      chk("t6_busy", 32'(busy), 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      obs_dat.delete(); obs_cyc.delete();
      q0.push_back({1'b1, 8'h95}); drive();
      run(6);
      chk("t6_cnt_ge1", 32'(obs_dat.size() >= 1), 1);
      if (obs_dat.size() >= 1) chk("t6_first", 32'(obs_dat[0]), {22'd0, 2'b01, 8'h95});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
